// File: rtl/fifo_sched.sv
// Four-queue to four-queue word scheduler with watermark ownership and init/error sequencing.
// Define FIFO_SCHED_PRIO_EN for fixed priority (queue 0 highest) instead of round-robin.
module fifo_sched #(
    parameter int DATA_BITS = 10,
    parameter int ADDR_BITS = 3,
    parameter int DEF_HIGH  = 6,
    parameter int DEF_LOW   = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic [ADDR_BITS-1:0]   cfg_high_limit,
    input  logic [ADDR_BITS-1:0]   cfg_low_limit,
    input  logic [3:0]             in_empty,
    input  logic [4*DATA_BITS-1:0] in_data,
    input  logic [3:0]             out_almost_full,
    input  logic [7:0]             fifo_error,
    output logic [3:0]             pop,
    output logic [3:0]             push,
    output logic [DATA_BITS-1:0]   out_data,
    output logic [ADDR_BITS-1:0]   high_limit_out,
    output logic [ADDR_BITS-1:0]   low_limit_out,
    output logic [2:0]             state_out,
    output logic                   idle_out,
    output logic                   error_out
);

    localparam logic [2:0] ST_RESET  = 3'd0;
    localparam logic [2:0] ST_INIT   = 3'd1;
    localparam logic [2:0] ST_IDLE   = 3'd2;
    localparam logic [2:0] ST_ACTIVE = 3'd3;
    localparam logic [2:0] ST_ERROR  = 3'd4;

    logic [2:0]           state_reg, state_next;
    logic                 v1_reg, v2_reg;
    logic [1:0]           sel_reg;
    logic [3:0]           push_reg;
    logic [DATA_BITS-1:0] out_data_reg;
    logic [ADDR_BITS-1:0] high_reg, low_reg;
    logic                 error_reg;

    logic                 pop_allowed;
    logic                 grant_valid;
    logic [1:0]           grant_idx;
    logic [1:0]           scan_idx;
    logic [1:0]           start;
    logic [3:0]           pop_next;
    logic                 err_hit;

    logic [DATA_BITS-1:0] words [4];
    logic [DATA_BITS-1:0] sel_word;
    logic [1:0]           dest;

    for (genvar gi = 0; gi < 4; gi++) begin : g_words
        assign words[gi] = in_data[gi*DATA_BITS +: DATA_BITS];
    end

    assign sel_word = words[sel_reg];
    assign dest     = sel_word[DATA_BITS-1 -: 2];

`ifdef FIFO_SCHED_PRIO_EN
    assign start = 2'd0;
`else
    logic [1:0] rr_reg;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rr_reg <= 2'd0;
        end else if (grant_valid) begin
            rr_reg <= grant_idx + 2'd1;
        end
    end

    assign start = rr_reg;
`endif

    // Gating on reset keeps the Mealy pop low during an asynchronous reset.
    assign pop_allowed = reset && !init && (fifo_error == 8'h00) && (out_almost_full == 4'h0) &&
                         ((state_reg == ST_ACTIVE) ||
                          ((state_reg == ST_IDLE) && (in_empty != 4'hF)));

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = 2'd0;
        scan_idx    = 2'd0;
        pop_next    = 4'h0;
        if (pop_allowed) begin
            for (int k = 0; k < 4; k++) begin
                scan_idx = start + 2'(k);
                if (!grant_valid && !in_empty[scan_idx]) begin
                    grant_valid = 1'b1;
                    grant_idx   = scan_idx;
                end
            end
        end
        pop_next[grant_idx] = grant_valid;
    end

    assign err_hit = (state_reg != ST_RESET) && (fifo_error != 8'h00);

    always_comb begin
        state_next = state_reg;
        if (err_hit) begin
            state_next = ST_ERROR;
        end else begin
            case (state_reg)
                ST_RESET:  state_next = ST_INIT;
                ST_INIT:   if (!init) state_next = ST_IDLE;
                ST_IDLE: begin
                    if (init)                    state_next = ST_INIT;
                    else if (in_empty != 4'hF)   state_next = ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (init)                    state_next = ST_INIT;
                    else if (in_empty == 4'hF)   state_next = ST_IDLE;
                end
                ST_ERROR:  state_next = ST_ERROR;
                default:   state_next = ST_ERROR;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg    <= ST_RESET;
            v1_reg       <= 1'b0;
            v2_reg       <= 1'b0;
            sel_reg      <= 2'd0;
            push_reg     <= 4'h0;
            out_data_reg <= '0;
            high_reg     <= ADDR_BITS'(DEF_HIGH);
            low_reg      <= ADDR_BITS'(DEF_LOW);
            error_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == ST_INIT) begin
                high_reg <= cfg_high_limit;
                low_reg  <= cfg_low_limit;
            end
            // Entering or sitting in ERROR flushes whatever is still in flight.
            if (state_next == ST_ERROR) begin
                v1_reg    <= 1'b0;
                v2_reg    <= 1'b0;
                push_reg  <= 4'h0;
                error_reg <= 1'b1;
            end else begin
                v1_reg   <= grant_valid;
                sel_reg  <= grant_idx;
                v2_reg   <= v1_reg;
                push_reg <= v1_reg ? (4'b0001 << dest) : 4'h0;
                if (v1_reg) begin
                    out_data_reg <= sel_word;
                end
            end
        end
    end

    assign pop            = pop_next;
    assign push           = push_reg;
    assign out_data       = out_data_reg;
    assign high_limit_out = high_reg;
    assign low_limit_out  = low_reg;
    assign state_out      = state_reg;
    assign idle_out       = (state_reg == ST_IDLE) && !v1_reg && !v2_reg;
    assign error_out      = error_reg;

endmodule

// File: doc/fifo_sched.md
Name: fifo_sched

Overview:
- Round-robin scheduler that drains four input xfifo-style queues into one shared output path and pushes each word into one of four output queues.
- The destination is selected by the two MSBs of each word.
- The block also owns the configuration of all eight FIFOs' high/low watermarks.
- It sequences init, normal traffic and error shutdown for the FIFO layer.

Parameters:
DATA_BITS, 10, word width; bits [DATA_BITS-1:DATA_BITS-2] are the destination index.
ADDR_BITS, 3, FIFO address width; also the width of the watermark fields.
DEF_HIGH, 6, high_limit_out value at reset.
DEF_LOW, 1, low_limit_out value at reset.

Ports:
clk  in  1  single clock, rising edge.
reset  in  1  asynchronous, active-low reset.
init  in  1  request configuration mode.
cfg_high_limit  in  ADDR_BITS  watermark to load while in INIT.
cfg_low_limit  in  ADDR_BITS  watermark to load while in INIT.
in_empty  in  4  empty flags of input FIFOs 0..3.
in_data  in  4*DATA_BITS  read data of input FIFOs; queue i occupies slice [i*DATA_BITS +: DATA_BITS].
out_almost_full  in  4  fifo_full_out (watermark) flags of output FIFOs.
fifo_error  in  8  error flags: [3:0] input FIFOs, [7:4] output FIFOs.
pop  out  4  read strobes to input FIFOs.
push  out  4  write strobes to output FIFOs.
out_data  out  DATA_BITS  write data broadcast to all output FIFOs.
high_limit_out  out  ADDR_BITS  watermark driven to all FIFOs.
low_limit_out  out  ADDR_BITS  watermark driven to all FIFOs.
state_out  out  3  encoded FSM state.
idle_out  out  1  high in IDLE with the pipeline empty.
error_out  out  1  sticky error flag.

Behaviour:
- FSM encoding: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.
- Reset (reset=0, asynchronous) sets:
  - state RESET; rr pointer 0; pipeline valid bits 0.
  - push=0, out_data=0, error_out=0, idle_out=0.
  - high_limit_out=DEF_HIGH, low_limit_out=DEF_LOW.
- pop is combinational, so it is 0 whenever reset=0.
- FSM transitions:
  - RESET -> INIT on the first edge after reset releases.
  - INIT: high_limit_out/low_limit_out are loaded from cfg_* on every clk edge while in INIT. Exit to IDLE when init=0.
  - IDLE -> ACTIVE when any in_empty bit is 0. ACTIVE -> IDLE when all in_empty bits are 1.
  - IDLE/ACTIVE -> INIT when init=1. Words already in the pipeline still complete their push.
  - Any state except RESET -> ERROR when any fifo_error bit is 1 at a clock edge. ERROR is left only by reset.
- Pop rule (combinational, Mealy):
  - Applies in ACTIVE and also in IDLE when in_empty is no longer all 1s.
  - A pop occurs only when init=0, no fifo_error bit is set, and out_almost_full==0.
  - Scan queues starting at rr; the first with in_empty=0 gets pop[i]=1.
  - At most one pop bit is high per cycle. On that edge, rr <= i+1 mod 4.
- Datapath pipeline:
  - Input FIFO read data is valid one cycle after pop (registered RAM read).
  - Cycle N: pop[i]. Edge end of N: sel<=i, v1<=1.
  - Edge end of N+1: out_data<=in_data[sel], dest<=out_data MSBs, v2<=1.
  - Cycle N+2: push[dest]=1 (registered). Pop-to-push latency is exactly 2 cycles.
  - One pop per cycle gives sustained throughput of 1 word/clk.
- Backpressure: any out_almost_full bit stalls all pops. Words already in flight (up to 2) still push; the watermark margin absorbs them.
- Write into a truly full output FIFO is the FIFO's own error; it is reported through fifo_error.
- ERROR state: pop=0 and push=0 from the cycle after entry, the pipeline is flushed, error_out=1.
- idle_out = (state==IDLE) && !v1 && !v2.
- Reset asserted mid-transfer: in-flight words are dropped and push falls to 0 immediately.

Optional Feature:
- Macro: FIFO_SCHED_PRIO_EN.
- When defined:
  - Fixed priority: queue 0 highest, queue 3 lowest.
  - The scan always starts at 0.
  - rr is not implemented.
- When undefined: round-robin as described above.
- All other timing is identical in both builds.

Test Plan:
1. Reset release, then init=1 for 2 cycles with cfg_high=5 and cfg_low=2 -> state_out goes 0 -> 1 -> 2; high_limit_out=5 and low_limit_out=2 after exit; pop=0 throughout.
2. Queue 2 holds one word 0x2C5 (dest 2), others empty -> pop=4'b0100 for exactly one cycle; push=4'b0100 with out_data=0x2C5 two cycles later; state returns to IDLE and idle_out=1.
3. All four queues hold 3 words each, no backpressure -> pop order 0,1,2,3,0,1,2,3,... with 12 consecutive pops; 12 pushes, each 2 cycles after its pop. With FIFO_SCHED_PRIO_EN: pop order 0,0,0,1,1,1,2,2,2,3,3,3.
4. Assert out_almost_full[1] mid-stream for 4 cycles -> pops stop in that same cycle; at most 2 further pushes occur; pops resume from the next rr queue when the flag clears.
5. Pulse fifo_error[5] for 1 cycle while ACTIVE -> state_out=4 and error_out=1; pop and push stay 0 until reset; then reset returns all outputs to their reset values.
6. Assert reset (async, mid-clock) with 2 words in flight -> push drops to 0 immediately; neither word is pushed after release; high_limit_out returns to 6.
